// File: rtl/fpm_stream_if.sv
`default_nettype none
// fpm_stream_if: operand stream, multiplier port and result stream of fpm_stream_ctrl.
// slave is the controller's view; master is the surrounding producer/multiplier/consumer.
interface fpm_stream_if #(
   parameter int N = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_a;
   logic [N-1:0] in_b;
   logic         fpm_en;
   logic [N-1:0] fpm_a;
   logic [N-1:0] fpm_b;
   logic [N-1:0] fpm_result;
   logic         fpm_of;
   logic         fpm_uf;
   logic         fpm_zf;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_result;
   logic [2:0]   out_flags;

   modport slave (
      input  in_valid, in_a, in_b, fpm_result, fpm_of, fpm_uf, fpm_zf, out_ready,
      output in_ready, fpm_en, fpm_a, fpm_b, out_valid, out_result, out_flags
   );

   modport master (
      output in_valid, in_a, in_b, fpm_result, fpm_of, fpm_uf, fpm_zf, out_ready,
      input  in_ready, fpm_en, fpm_a, fpm_b, out_valid, out_result, out_flags
   );
endinterface
`default_nettype wire

// File: rtl/fpm_stream_ctrl.sv
`default_nettype none
// fpm_stream_ctrl: valid/ready front-end for a 2-stage enabled FP multiplier,
// with a result FIFO and saturating per-flag event counters.
module fpm_stream_ctrl #(
   parameter int N     = 32,
   parameter int DEPTH = 4,
   parameter int CW    = 16
) (
   input  logic          clk,
   input  logic          reset,
   fpm_stream_if.slave   bus,
   output logic [CW-1:0] of_count_o,
   output logic [CW-1:0] uf_count_o,
   output logic [CW-1:0] zf_count_o
);
   localparam int          AW       = $clog2(DEPTH);
   localparam int          EW       = N + 3;
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic          v0_q, v0_d;
   logic          v1_q, v1_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic [CW-1:0] ofc_q, ofc_d;
   logic [CW-1:0] ufc_q, ufc_d;
   logic [CW-1:0] zfc_q, zfc_d;
   logic [EW-1:0] mem_q [DEPTH];

   logic          full;
   logic          stall;
   logic          rdy;
   logic          en;
   logic          ovalid;
   logic          push;
   logic          pop;
   logic [EW-1:0] push_entry;
   logic [EW-1:0] head;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c, input logic hit);
      return (hit && (c != {CW{1'b1}})) ? c + CW'(1) : c;
   endfunction

   // Full is judged on the registered count only, so a same-cycle pop never
   // relieves a stall and in_ready has no path from out_ready.
   assign full       = (count_q == FULL_CNT);
   assign stall      = v1_q & full;
   assign rdy        = ~reset & ~stall;
   assign en         = ~reset & ~stall & (bus.in_valid | v0_q | v1_q);
   assign ovalid     = ~reset & (count_q != '0);
   assign push       = en & v1_q;
   assign pop        = ovalid & bus.out_ready;
   assign push_entry = {bus.fpm_result, bus.fpm_of, bus.fpm_uf, bus.fpm_zf};
   assign head       = mem_q[rptr_q];

   assign bus.in_ready   = rdy;
   assign bus.fpm_en     = en;
   assign bus.fpm_a      = bus.in_a;
   assign bus.fpm_b      = bus.in_b;
   assign bus.out_valid  = ovalid;
   assign bus.out_result = head[EW-1:3];
   assign bus.out_flags  = head[2:0];

   assign of_count_o = ofc_q;
   assign uf_count_o = ufc_q;
   assign zf_count_o = zfc_q;

   always_comb begin
      v0_d    = v0_q;
      v1_d    = v1_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (en) begin
         v0_d = bus.in_valid & rdy;
         v1_d = v0_q;
      end
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
      ofc_d = sat_inc(ofc_q, push & bus.fpm_of);
      ufc_d = sat_inc(ufc_q, push & bus.fpm_uf);
      zfc_d = sat_inc(zfc_q, push & bus.fpm_zf);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v0_q    <= 1'b0;
         v1_q    <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ofc_q   <= '0;
         ufc_q   <= '0;
         zfc_q   <= '0;
      end else begin
         v0_q    <= v0_d;
         v1_q    <= v1_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ofc_q   <= ofc_d;
         ufc_q   <= ufc_d;
         zfc_q   <= zfc_d;
      end
   end

   // Storage needs no reset: entries are only read while count says they are valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= push_entry;
   end
endmodule
`default_nettype wire

// File: tb/tb_fpm_stream_ctrl.sv
`default_nettype none
// Directed table-driven bench for fpm_stream_ctrl, with a behavioural
// 2-stage enabled FP multiplier attached to each controller instance.
module tb_fpm_stream_ctrl;
   localparam int N = 32;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic [2:0]  f;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fpm_stream_if #(.N(N)) bus ();
   fpm_stream_if #(.N(N)) bus2 ();
   logic [15:0] ofc, ufc, zfc;
   logic [3:0]  ofc2, ufc2, zfc2;

   fpm_stream_ctrl #(.N(N), .DEPTH(4), .CW(16)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .of_count_o(ofc), .uf_count_o(ufc), .zf_count_o(zfc)
   );

   fpm_stream_ctrl #(.N(N), .DEPTH(4), .CW(4)) dut_sat (
      .clk(clk), .reset(reset), .bus(bus2),
      .of_count_o(ofc2), .uf_count_o(ufc2), .zf_count_o(zfc2)
   );

   // Simplified single-precision multiply: zero inputs give zero, exponent
   // range violations give inf (overflow) or zero (underflow), mantissa truncated.
   function automatic logic [34:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      int          e;
      logic [47:0] m;
      logic [22:0] f;
      s = a[31] ^ b[31];
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0, 3'b001};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      if (m[47]) begin
         e = e + 1;
         f = m[46:24];
      end else begin
         f = m[45:23];
      end
      if (e >= 255) return {s, 8'hFF, 23'd0, 3'b100};
      if (e <= 0)   return {s, 31'd0, 3'b010};
      return {s, e[7:0], f, 3'b000};
   endfunction

   logic [63:0] m1_s1_q, m2_s1_q;
   logic [34:0] m1_s2_q, m2_s2_q;

   always @(posedge clk) begin
      if (reset) begin
         m1_s1_q <= '0;
         m1_s2_q <= '0;
      end else if (bus.fpm_en) begin
         m1_s1_q <= {bus.fpm_a, bus.fpm_b};
         m1_s2_q <= fmul(m1_s1_q[63:32], m1_s1_q[31:0]);
      end
   end

   always @(posedge clk) begin
      if (reset) begin
         m2_s1_q <= '0;
         m2_s2_q <= '0;
      end else if (bus2.fpm_en) begin
         m2_s1_q <= {bus2.fpm_a, bus2.fpm_b};
         m2_s2_q <= fmul(m2_s1_q[63:32], m2_s1_q[31:0]);
      end
   end

   assign bus.fpm_result  = m1_s2_q[34:3];
   assign bus.fpm_of      = m1_s2_q[2];
   assign bus.fpm_uf      = m1_s2_q[1];
   assign bus.fpm_zf      = m1_s2_q[0];
   assign bus2.fpm_result = m2_s2_q[34:3];
   assign bus2.fpm_of     = m2_s2_q[2];
   assign bus2.fpm_uf     = m2_s2_q[1];
   assign bus2.fpm_zf     = m2_s2_q[0];
   assign bus2.in_valid   = bus.in_valid;
   assign bus2.in_a       = bus.in_a;
   assign bus2.in_b       = bus.in_b;
   assign bus2.out_ready  = bus.out_ready;

   vec_t vt [13];
   vec_t src_q[$];
   vec_t exp_q[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   n_acc, n_out, n_stall, n_noen, cyc;
   logic send_en, acc_now, ov_now, rdy_now;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   task automatic clr();
      n_acc = 0; n_out = 0; n_stall = 0; n_noen = 0;
   endtask

   // One clock: drive at posedge+1, observe handshakes and score at negedge.
   task automatic step();
      vec_t e;
      if (send_en && src_q.size() > 0) begin
         bus.in_valid = 1'b1;
         bus.in_a     = src_q[0].a;
         bus.in_b     = src_q[0].b;
      end else begin
         bus.in_valid = 1'b0;
      end
      @(negedge clk);
      acc_now = bus.in_valid && bus.in_ready;
      ov_now  = bus.out_valid;
      rdy_now = bus.in_ready;
      if (bus.in_valid && !bus.in_ready) n_stall++;
      if (bus.in_valid && !bus.fpm_en)   n_noen++;
      if (acc_now) begin
         exp_q.push_back(src_q.pop_front());
         n_acc++;
      end
      if (bus.out_valid && bus.out_ready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL spurious_out: got %0h expected no output", bus.out_result);
         end else begin
            e = exp_q.pop_front();
            chk("out_result", bus.out_result, e.r);
            chk("out_flags", bus.out_flags, e.f);
         end
      end
      cyc++;
      @(posedge clk); #1;
   endtask

   task automatic run_until_out(input int target, input int bound);
      for (int i = 0; i < bound && n_out < target; i++) step();
   endtask

   task automatic single_latency(input vec_t v, input string nm);
      int acc_cyc, ov_cyc;
      acc_cyc = -1;
      ov_cyc  = -1;
      src_q.push_back(v);
      for (int i = 0; i < 12 && ov_cyc < 0; i++) begin
         step();
         if (acc_now) acc_cyc = cyc;
         if (ov_now && acc_cyc >= 0 && ov_cyc < 0) ov_cyc = cyc;
      end
      chk(nm, ov_cyc - acc_cyc, 3);
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      src_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int pop_cyc, rdy_cyc;
      vt[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 3'b000};
      vt[1]  = '{32'h3F800000, 32'h40000000, 32'h40000000, 3'b000};
      vt[2]  = '{32'h40000000, 32'h40000000, 32'h40800000, 3'b000};
      vt[3]  = '{32'h40400000, 32'h40000000, 32'h40C00000, 3'b000};
      vt[4]  = '{32'h40800000, 32'h40000000, 32'h41000000, 3'b000};
      vt[5]  = '{32'h40A00000, 32'h40000000, 32'h41200000, 3'b000};
      vt[6]  = '{32'h40C00000, 32'h40000000, 32'h41400000, 3'b000};
      vt[7]  = '{32'h40E00000, 32'h40000000, 32'h41600000, 3'b000};
      vt[8]  = '{32'h41000000, 32'h40000000, 32'h41800000, 3'b000};
      vt[9]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100};
      vt[10] = '{32'h00800000, 32'h00800000, 32'h00000000, 3'b010};
      vt[11] = '{32'h00000000, 32'h3F800000, 32'h00000000, 3'b001};
      vt[12] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000};
      cyc     = 0;
      send_en = 1'b1;
      clr();

      // Reset state, with a valid pair presented while reset is high.
      reset         = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_a      = 32'h3F800000;
      bus.in_b      = 32'h3F800000;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_fpm_en", bus.fpm_en, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_counters", {ofc, ufc, zfc}, 0);
      @(posedge clk); #1;
      reset        = 1'b0;
      bus.in_valid = 1'b0;

      // Single pair latency and value.
      clr();
      single_latency(vt[0], "single_latency");
      repeat (3) step();
      chk("single_count", n_out, 1);

      // Back-to-back stream with a free consumer.
      clr();
      for (int i = 1; i <= 8; i++) src_q.push_back(vt[i]);
      run_until_out(8, 40);
      chk("b2b_count", n_out, 8);
      chk("b2b_in_ready_drops", n_stall, 0);
      chk("b2b_fpm_en_gaps", n_noen, 0);

      // Backpressure: DEPTH+2 accepted, then drain and finish.
      clr();
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) src_q.push_back(vt[i]);
      src_q.push_back(vt[0]);
      src_q.push_back(vt[12]);
      repeat (16) step();
      chk("bp_accepted", n_acc, 6);
      chk("bp_in_ready", rdy_now, 0);
      chk("bp_out_valid", ov_now, 1);
      bus.out_ready = 1'b1;
      pop_cyc = -1;
      rdy_cyc = -1;
      for (int i = 0; i < 60 && n_out < 10; i++) begin
         step();
         if (pop_cyc < 0 && n_out > 0) pop_cyc = cyc;
         else if (pop_cyc >= 0 && rdy_cyc < 0 && rdy_now) rdy_cyc = cyc;
      end
      chk("bp_ready_return", rdy_cyc - pop_cyc, 1);
      chk("bp_drained", n_out, 10);
      chk("bp_total_acc", n_acc, 10);

      // Flag capture and counters.
      do_reset();
      clr();
      for (int i = 9; i <= 11; i++) src_q.push_back(vt[i]);
      run_until_out(3, 30);
      chk("flags_count", n_out, 3);
      chk("of_count", ofc, 1);
      chk("uf_count", ufc, 1);
      chk("zf_count", zfc, 1);

      // Saturation of a narrow counter.
      do_reset();
      clr();
      for (int i = 0; i < 20; i++) src_q.push_back(vt[11]);
      run_until_out(20, 80);
      chk("sat_outputs", n_out, 20);
      chk("zf_count_wide", zfc, 20);
      chk("zf_count_sat", zfc2, 15);
      chk("of_uf_count_sat", {ofc2, ufc2}, 0);

      // Reset with two pairs in flight and three results queued.
      do_reset();
      clr();
      bus.out_ready = 1'b0;
      src_q.push_back(vt[11]);
      src_q.push_back(vt[11]);
      src_q.push_back(vt[11]);
      src_q.push_back(vt[11]);
      src_q.push_back(vt[11]);
      for (int i = 0; i < 20 && n_acc < 5; i++) step();
      chk("mid_zf_before", zfc, 3);
      reset        = 1'b1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_in_ready", bus.in_ready, 0);
      chk("mid_rst_fpm_en", bus.fpm_en, 0);
      @(posedge clk); #1;
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      src_q.delete();
      exp_q.delete();
      @(negedge clk);
      chk("post_rst_out_valid", bus.out_valid, 0);
      chk("post_rst_counters", {ofc, ufc, zfc}, 0);
      @(posedge clk); #1;
      clr();
      bus.out_ready = 1'b1;
      single_latency(vt[12], "post_rst_latency");
      repeat (5) step();
      chk("post_rst_outputs", n_out, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
